mealy_cm_seq: RTL

//  Parametrised Mealy control-matrix sequencer, successor to the single-sequence control matrix.

---
 rtl/mealy_cm_seq_if.sv | 48 ++++
 rtl/mealy_cm_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mealy_cm_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mealy_cm_seq_if
// Description : Bus between the control-matrix sequencer and the datapath.
//               The sequencer (master) receives opcode, zero flag, memory
//               ready and resume, and drives the active-low strobes, the PC
//               and address source selects, and the halt/fault status.
//               The datapath/board side (slave) sees the opposite directions.
// Ports       : ir_opcode_i, zero_flag_i, mem_ready_i, resume_i  (to seq)
//               pc_rst_no, pc_ld_no, mar_rst_no, mar_ld_no, ir_ld_no,
//               reg_ld_no, mem_rd_no, pc_src_o, addr_src_o,
//               halted_o, fault_o                                (from seq)
// Revision    : 1.0 - initial release
// ============================================================================
interface mealy_cm_seq_if #(
  parameter int OPCODE_WIDTH     = 4,
  parameter int PC_SELECT_SIZE   = 3,
  parameter int ADDR_SELECT_SIZE = 2
);
  logic [OPCODE_WIDTH-1:0]     ir_opcode_i;
  logic                        zero_flag_i;
  logic                        mem_ready_i;
  logic                        resume_i;
  logic                        pc_rst_no;
  logic                        pc_ld_no;
  logic                        mar_rst_no;
  logic                        mar_ld_no;
  logic                        ir_ld_no;
  logic                        reg_ld_no;
  logic                        mem_rd_no;
  logic [PC_SELECT_SIZE-1:0]   pc_src_o;
  logic [ADDR_SELECT_SIZE-1:0] addr_src_o;
  logic                        halted_o;
  logic                        fault_o;

  modport master (
    input  ir_opcode_i, zero_flag_i, mem_ready_i, resume_i,
    output pc_rst_no, pc_ld_no, mar_rst_no, mar_ld_no, ir_ld_no, reg_ld_no,
           mem_rd_no, pc_src_o, addr_src_o, halted_o, fault_o
  );

  modport slave (
    output ir_opcode_i, zero_flag_i, mem_ready_i, resume_i,
    input  pc_rst_no, pc_ld_no, mar_rst_no, mar_ld_no, ir_ld_no, reg_ld_no,
           mem_rd_no, pc_src_o, addr_src_o, halted_o, fault_o
  );
endinterface
`default_nettype wire

// File: rtl/mealy_cm_seq.sv
`default_nettype none
// ============================================================================
// Module      : mealy_cm_seq
// Description : Mealy control-matrix sequencer. Active-low datapath strobes
//               and PC/address selects are decoded combinationally from the
//               state register plus the live opcode, zero flag, memory ready
//               and resume inputs. Adds fetch/operand wait states with a bus
//               timeout watchdog, an illegal-opcode trap and halt/resume.
//               State updates on the falling clock edge.
// Ports       : clk_i     - clock (state changes on negedge)
//               reset_ni  - asynchronous active-low reset
//               bus       - mealy_cm_seq_if.master (inputs + strobes/status)
// Revision    : 1.0 - initial release
// ============================================================================
module mealy_cm_seq #(
  parameter int OPCODE_WIDTH     = 4,
  parameter int PC_SELECT_SIZE   = 3,
  parameter int ADDR_SELECT_SIZE = 2,
  parameter int WAIT_MAX         = 7
) (
  input  wire            clk_i,
  input  wire            reset_ni,
  mealy_cm_seq_if.master bus
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  localparam logic [OPCODE_WIDTH-1:0] c_OP_NOP = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_LDI = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_JMP = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_BRZ = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_HLT = OPCODE_WIDTH'(4);

  localparam logic [PC_SELECT_SIZE-1:0] c_PC_INC  = PC_SELECT_SIZE'(0);
  localparam logic [PC_SELECT_SIZE-1:0] c_PC_RST  = PC_SELECT_SIZE'(1);
  localparam logic [PC_SELECT_SIZE-1:0] c_PC_IR   = PC_SELECT_SIZE'(2);
  localparam logic [PC_SELECT_SIZE-1:0] c_PC_TRAP = PC_SELECT_SIZE'(3);

  localparam logic [ADDR_SELECT_SIZE-1:0] c_ADDR_PC = ADDR_SELECT_SIZE'(0);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_VECTOR = 3'd1,
    S_FETCH  = 3'd2,
    S_EXEC   = 3'd3,
    S_OPND   = 3'd4,
    S_TRAP   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;
  logic [CNT_W-1:0] w_wait_inc;
  logic             w_timeout;

  // Saturating increment; timeout fires on the WAIT_MAX-th consecutive
  // not-ready cycle, but only if ready is still low on that cycle.
  assign w_wait_inc = (r_wait_cnt == CNT_W'(WAIT_MAX)) ? r_wait_cnt
                                                       : r_wait_cnt + 1'b1;
  assign w_timeout  = (w_wait_inc == CNT_W'(WAIT_MAX));

  always_ff @(negedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state    <= S_RESET;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = '0;
    bus.pc_rst_no  = 1'b1;
    bus.pc_ld_no   = 1'b1;
    bus.mar_rst_no = 1'b1;
    bus.mar_ld_no  = 1'b1;
    bus.ir_ld_no   = 1'b1;
    bus.reg_ld_no  = 1'b1;
    bus.mem_rd_no  = 1'b1;
    bus.pc_src_o   = c_PC_INC;
    bus.addr_src_o = c_ADDR_PC;
    bus.halted_o   = 1'b0;
    bus.fault_o    = 1'b0;

    case (r_state)
      S_RESET: begin
        bus.pc_rst_no  = 1'b0;
        bus.mar_rst_no = 1'b0;
        w_state_nxt    = S_VECTOR;
      end

      S_VECTOR: begin
        bus.pc_ld_no = 1'b0;
        bus.pc_src_o = c_PC_RST;
        w_state_nxt  = S_FETCH;
      end

      // FETCH and OPND share the memory-read/wait behaviour; they differ
      // only in which register captures the data and where they go next.
      S_FETCH, S_OPND: begin
        bus.mar_ld_no  = 1'b0;
        bus.mem_rd_no  = 1'b0;
        bus.addr_src_o = c_ADDR_PC;
        if (bus.mem_ready_i) begin
          bus.pc_ld_no = 1'b0;
          bus.pc_src_o = c_PC_INC;
          if (r_state == S_FETCH) begin
            bus.ir_ld_no = 1'b0;
            w_state_nxt  = S_EXEC;
          end else begin
            bus.reg_ld_no = 1'b0;
            w_state_nxt   = S_FETCH;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_TRAP;
        end else begin
          w_wait_cnt_nxt = w_wait_inc;
        end
      end

      S_EXEC: begin
        case (bus.ir_opcode_i)
          c_OP_NOP: w_state_nxt = S_FETCH;
          c_OP_LDI: w_state_nxt = S_OPND;
          c_OP_JMP: begin
            bus.pc_ld_no = 1'b0;
            bus.pc_src_o = c_PC_IR;
            w_state_nxt  = S_FETCH;
          end
          c_OP_BRZ: begin
            if (bus.zero_flag_i) begin
              bus.pc_ld_no = 1'b0;
              bus.pc_src_o = c_PC_IR;
            end
            w_state_nxt = S_FETCH;
          end
          c_OP_HLT: w_state_nxt = S_HALT;
          default:  w_state_nxt = S_TRAP;
        endcase
      end

      S_TRAP: begin
        bus.pc_ld_no = 1'b0;
        bus.pc_src_o = c_PC_TRAP;
        bus.fault_o  = 1'b1;
        w_state_nxt  = S_FETCH;
      end

      S_HALT: begin
        bus.halted_o = 1'b1;
        if (bus.resume_i) begin
          w_state_nxt = S_FETCH;
        end
      end

      default: w_state_nxt = S_RESET;
    endcase
  end

endmodule
`default_nettype wire
